// File: rtl/mem_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_read_pkg
//  Description : Shared geometry and state encoding for the stream-output
//                memory read arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_read_pkg;

   localparam int NMEM   = 12;  // number of input memories
   localparam int NENT_W = 7;   // entry count width (0..64 meaningful)
   localparam int ADDR_W = 6;   // memory read address width
   localparam int BX_W   = 3;   // BX tag width
   localparam int SEL_W  = 4;   // binary port-select width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_read_arbiter_prio_enc12.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc12
//  Description : Combinational lowest-index-first priority encoder. Returns
//                the binary index of the lowest set request bit and a flag
//                telling whether any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc12
   import mem_read_pkg::*;
#(
   parameter int N = NMEM
)(
   input  logic [N-1:0]     req,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   // Walk from the top down so the lowest set bit is the final writer.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = SEL_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_read_arbiter
//  Description : Per-BX read sequencer for the 12 stream-output memories.
//                Snapshots entry counts on start, drains the memories one
//                read per cycle in fixed low-index-first priority under a
//                per-BX read budget, and delays {valid, sel, bx} by the
//                memory read latency. Memory geometry comes from the package.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_read_arbiter
   import mem_read_pkg::*;
#(
   parameter int RD_LAT    = 2,
   parameter int MAX_READS = 100
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [BX_W-1:0]        bx_in,
   input  logic [NMEM*NENT_W-1:0] nent,
   output logic [NMEM-1:0]        rd_en,
   output logic [ADDR_W-1:0]      rd_addr,
   output logic [SEL_W-1:0]       sel,
   output logic [BX_W-1:0]        bx_out,
   output logic                   sel_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   truncated
);

   localparam int                  c_CNT_W   = $clog2(MAX_READS + 1);
   localparam logic [NENT_W-1:0]   c_MAX_ENT = NENT_W'(1 << ADDR_W);
   localparam logic [c_CNT_W-1:0]  c_BUDGET  = c_CNT_W'(MAX_READS);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NENT_W-1:0]   r_snap [NMEM];
   logic [NENT_W-1:0]   r_ptr  [NMEM];
   logic [c_CNT_W-1:0]  r_cnt;
   logic [BX_W-1:0]     r_bx;

   logic [NMEM-1:0]     w_req;
   logic [SEL_W-1:0]    w_idx;
   logic                w_any;
   logic                w_load;
   logic                w_issue;
   logic                w_done_nxt;
   logic                w_trunc_nxt;
   logic                w_busy_nxt;

   logic [NMEM-1:0]     r_rd_en;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_busy;
   logic                r_done;
   logic                r_trunc;

   // Stage 0 runs alongside rd_en; stage RD_LAT lines up with memory data.
   logic                r_dv   [RD_LAT+1];
   logic [SEL_W-1:0]    r_didx [RD_LAT+1];
   logic [BX_W-1:0]     r_dbx  [RD_LAT+1];

   // A memory can hold at most 2**ADDR_W entries; larger counts saturate.
   function automatic logic [NENT_W-1:0] clamp_ent(input logic [NENT_W-1:0] n);
      return (n > c_MAX_ENT) ? c_MAX_ENT : n;
   endfunction

   // A memory still has work while its read pointer trails its snapshot.
   always_comb begin
      for (int i = 0; i < NMEM; i++) begin
         w_req[i] = (r_ptr[i] < r_snap[i]);
      end
   end

   prio_enc12 #(.N(NMEM)) u_prio_enc (
      .req (w_req),
      .idx (w_idx),
      .any (w_any)
   );

   // Next-state and per-cycle control; a start always wins over draining.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_issue     = 1'b0;
      w_done_nxt  = 1'b0;
      w_trunc_nxt = 1'b0;
      w_busy_nxt  = r_busy;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (start) begin
               // Close the current BX and open the next on the same edge.
               w_load      = 1'b1;
               w_done_nxt  = 1'b1;
               w_trunc_nxt = w_any;
               w_busy_nxt  = 1'b1;
            end else if (!w_any) begin
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = DONE;
            end else if (r_cnt == c_BUDGET) begin
               w_done_nxt  = 1'b1;
               w_trunc_nxt = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = DONE;
            end else begin
               w_issue     = 1'b1;
            end
         end
         DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = SCAN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Snapshot, read pointers, read budget counter and BX tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NMEM; i++) begin
            r_snap[i] <= '0;
            r_ptr[i]  <= '0;
         end
         r_cnt <= '0;
         r_bx  <= '0;
      end else if (w_load) begin
         for (int i = 0; i < NMEM; i++) begin
            r_snap[i] <= clamp_ent(nent[i*NENT_W +: NENT_W]);
            r_ptr[i]  <= '0;
         end
         r_cnt <= '0;
         r_bx  <= bx_in;
      end else if (w_issue) begin
         r_ptr[w_idx] <= r_ptr[w_idx] + 1'b1;
         r_cnt        <= r_cnt + 1'b1;
      end
   end

   // Registered read strobes and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en   <= '0;
         r_rd_addr <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_trunc   <= 1'b0;
      end else begin
         r_rd_en <= w_issue ? (NMEM'(1) << w_idx) : '0;
         if (w_issue) r_rd_addr <= r_ptr[w_idx][ADDR_W-1:0];
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_trunc <= w_trunc_nxt;
      end
   end

   // Delay line; index and tag only advance with a valid entry so sel holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j <= RD_LAT; j++) begin
            r_dv[j]   <= 1'b0;
            r_didx[j] <= '0;
            r_dbx[j]  <= '0;
         end
      end else begin
         r_dv[0] <= w_issue;
         if (w_issue) begin
            r_didx[0] <= w_idx;
            r_dbx[0]  <= r_bx;
         end
         for (int j = 1; j <= RD_LAT; j++) begin
            r_dv[j] <= r_dv[j-1];
            if (r_dv[j-1]) begin
               r_didx[j] <= r_didx[j-1];
               r_dbx[j]  <= r_dbx[j-1];
            end
         end
      end
   end

   assign rd_en     = r_rd_en;
   assign rd_addr   = r_rd_addr;
   assign sel       = r_didx[RD_LAT];
   assign bx_out    = r_dbx[RD_LAT];
   assign sel_valid = r_dv[RD_LAT];
   assign busy      = r_busy;
   assign done      = r_done;
   assign truncated = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_read_arbiter
//  Description : Self-checking bench for mem_read_arbiter. A queue-based
//                reference model predicts every output each cycle; directed
//                scenarios add literal expectations; a random phase mixes
//                BX sizes, aborting starts and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_arbiter;
   import mem_read_pkg::*;

   localparam int RD_LAT    = 2;
   localparam int MAX_READS = 100;

   typedef struct packed { logic [SEL_W-1:0] mem; logic [ADDR_W-1:0] addr; } rd_t;
   typedef struct packed { logic v; logic [SEL_W-1:0] mem; logic [BX_W-1:0] bx; } dl_t;

   logic                   clk   = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic [BX_W-1:0]        bx_in = '0;
   logic [NMEM*NENT_W-1:0] nent  = '0;
   logic [NMEM-1:0]        rd_en;
   logic [ADDR_W-1:0]      rd_addr;
   logic [SEL_W-1:0]       sel;
   logic [BX_W-1:0]        bx_out;
   logic                   sel_valid;
   logic                   busy;
   logic                   done;
   logic                   truncated;

   always #5 clk = ~clk;

   mem_read_arbiter #(.RD_LAT(RD_LAT), .MAX_READS(MAX_READS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bx_in     (bx_in),
      .nent      (nent),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .sel       (sel),
      .bx_out    (bx_out),
      .sel_valid (sel_valid),
      .busy      (busy),
      .done      (done),
      .truncated (truncated)
   );

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int start_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   rd_t             m_q[$];
   dl_t             m_dq[$];
   bit              m_active = 1'b0;
   int              m_issued = 0;
   logic [BX_W-1:0] m_bx     = '0;
   logic [NMEM-1:0]   e_rd_en = '0;
   logic [ADDR_W-1:0] e_addr  = '0;
   logic [SEL_W-1:0]  e_sel   = '0;
   logic [BX_W-1:0]   e_bx    = '0;
   logic              e_sv    = 1'b0;
   logic              e_busy  = 1'b0;
   logic              e_done  = 1'b0;
   logic              e_trunc = 1'b0;

   function automatic void m_reset();
      m_q.delete();
      m_dq.delete();
      for (int i = 0; i < RD_LAT; i++) m_dq.push_back('0);
      m_active = 1'b0; m_issued = 0; m_bx = '0;
      e_rd_en = '0; e_addr = '0; e_sel = '0; e_bx = '0;
      e_sv = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_trunc = 1'b0;
   endfunction

   // Predict the outputs that follow each rising edge.
   always @(posedge clk or negedge rst_n) begin : p_model
      rd_t              r;
      dl_t              d;
      logic             iss;
      logic [SEL_W-1:0] im;
      int               n;
      if (!rst_n) begin
         m_reset();
      end else begin
         iss = 1'b0; im = '0;
         e_rd_en = '0; e_done = 1'b0; e_trunc = 1'b0;
         if (start) begin
            if (m_active) begin
               e_done  = 1'b1;
               e_trunc = (m_q.size() != 0);
            end
            m_q.delete();
            for (int m = 0; m < NMEM; m++) begin
               n = int'(nent[m*NENT_W +: NENT_W]);
               if (n > 64) n = 64;
               for (int a = 0; a < n; a++) m_q.push_back({SEL_W'(m), ADDR_W'(a)});
            end
            m_issued = 0; m_active = 1'b1; m_bx = bx_in; e_busy = 1'b1;
         end else if (m_active) begin
            if (m_q.size() == 0) begin
               e_done = 1'b1; m_active = 1'b0; e_busy = 1'b0;
            end else if (m_issued == MAX_READS) begin
               e_done = 1'b1; e_trunc = 1'b1; m_active = 1'b0; e_busy = 1'b0;
            end else begin
               r = m_q.pop_front();
               e_rd_en[r.mem] = 1'b1;
               e_addr = r.addr;
               m_issued++;
               iss = 1'b1; im = r.mem;
            end
         end
         m_dq.push_back({iss, im, m_bx});
         d = m_dq.pop_front();
         e_sv = d.v;
         if (d.v) begin
            e_sel = d.mem;
            e_bx  = d.bx;
         end
      end
   end

   // ---------------- compare and observation log ----------------
   rd_t                   rd_log[$];
   logic [SEL_W+BX_W-1:0] sv_log[$];
   int                    done_cyc[$];
   logic                  done_tr[$];
   int                    first_rd = -1;
   int                    first_sv = -1;

   always @(negedge clk) begin : p_cmp
      cyc++;
      chk("rd_en", 32'(rd_en), 32'(e_rd_en));
      if (e_rd_en != '0) chk("rd_addr", 32'(rd_addr), 32'(e_addr));
      chk("sel_valid", 32'(sel_valid), 32'(e_sv));
      chk("sel", 32'(sel), 32'(e_sel));
      chk("bx_out", 32'(bx_out), 32'(e_bx));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("truncated", 32'(truncated), 32'(e_trunc));
      if (rd_en != '0) begin
         for (int m = 0; m < NMEM; m++) if (rd_en[m]) rd_log.push_back({SEL_W'(m), rd_addr});
         if (first_rd < 0) first_rd = cyc;
      end
      if (sel_valid) begin
         sv_log.push_back({sel, bx_out});
         if (first_sv < 0) first_sv = cyc;
      end
      if (done) begin
         done_cyc.push_back(cyc);
         done_tr.push_back(truncated);
      end
   end

   function automatic logic [31:0] rd_at(input int i);
      return (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] sv_at(input int i);
      return (i < sv_log.size()) ? 32'(sv_log[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] tr_at(input int i);
      return (i < done_tr.size()) ? 32'(done_tr[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] dlat_at(input int i);
      return (i < done_cyc.size()) ? 32'(done_cyc[i] - start_cyc) : 32'hFFFF_FFFF;
   endfunction

   task automatic clear_logs();
      rd_log.delete(); sv_log.delete(); done_cyc.delete(); done_tr.delete();
      first_rd = -1; first_sv = -1;
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [BX_W-1:0] b, input logic [NMEM*NENT_W-1:0] v);
      start = 1'b1; bx_in = b; nent = v; start_cyc = cyc;
      step();
      start = 1'b0;
   endtask

   function automatic logic [NMEM*NENT_W-1:0] all_ent(input int val);
      logic [NMEM*NENT_W-1:0] v;
      for (int m = 0; m < NMEM; m++) v[m*NENT_W +: NENT_W] = NENT_W'(val);
      return v;
   endfunction

   initial begin : p_watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : p_stim
      logic [NMEM*NENT_W-1:0] v;
      int                     cnt;
      int                     val;

      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(2);

      // m0:2, m3:1, bx 5
      v = '0; v[0*NENT_W +: NENT_W] = 7'd2; v[3*NENT_W +: NENT_W] = 7'd1;
      clear_logs(); pulse_start(3'd5, v); step(12);
      chk("s1_nreads", 32'(rd_log.size()), 3);
      chk("s1_rd0", rd_at(0), 0);
      chk("s1_rd1", rd_at(1), 1);
      chk("s1_rd2", rd_at(2), 3 * 64);
      chk("s1_rd_lat", 32'(first_rd - start_cyc), 2);
      chk("s1_sv_lat", 32'(first_sv - first_rd), RD_LAT);
      chk("s1_nsv", 32'(sv_log.size()), 3);
      chk("s1_sv0", sv_at(0), 5);
      chk("s1_sv2", sv_at(2), 3 * 8 + 5);
      chk("s1_ndone", 32'(done_cyc.size()), 1);
      chk("s1_trunc", tr_at(0), 0);
      chk("s1_done_lat", dlat_at(0), 5);

      // all counts zero
      clear_logs(); pulse_start(3'd2, '0); step(6);
      chk("s2_nreads", 32'(rd_log.size()), 0);
      chk("s2_ndone", 32'(done_cyc.size()), 1);
      chk("s2_done_lat", dlat_at(0), 2);
      chk("s2_trunc", tr_at(0), 0);

      // every memory full: budget cuts at 100
      clear_logs(); pulse_start(3'd3, all_ent(64)); step(110);
      chk("s3_nreads", 32'(rd_log.size()), 100);
      chk("s3_rd63", rd_at(63), 63);
      chk("s3_rd64", rd_at(64), 64);
      chk("s3_rd99", rd_at(99), 64 + 35);
      chk("s3_ndone", 32'(done_cyc.size()), 1);
      chk("s3_trunc", tr_at(0), 1);

      // new start three reads into a 10-entry BX
      v = '0; v[2*NENT_W +: NENT_W] = 7'd10;
      clear_logs(); pulse_start(3'd1, v); step(3);
      v = '0; v[5*NENT_W +: NENT_W] = 7'd4;
      pulse_start(3'd2, v); step(15);
      chk("s4_nreads", 32'(rd_log.size()), 7);
      chk("s4_rd2", rd_at(2), 2 * 64 + 2);
      chk("s4_rd3", rd_at(3), 5 * 64);
      chk("s4_rd6", rd_at(6), 5 * 64 + 3);
      chk("s4_ndone", 32'(done_cyc.size()), 2);
      chk("s4_trunc0", tr_at(0), 1);
      chk("s4_trunc1", tr_at(1), 0);
      chk("s4_sv2", sv_at(2), 2 * 8 + 1);
      chk("s4_sv3", sv_at(3), 5 * 8 + 2);
      chk("s4_nsv", 32'(sv_log.size()), 7);

      // m11 above the clamp
      v = '0; v[11*NENT_W +: NENT_W] = 7'd70;
      clear_logs(); pulse_start(3'd4, v); step(75);
      chk("s5_nreads", 32'(rd_log.size()), 64);
      chk("s5_rd63", rd_at(63), 11 * 64 + 63);
      cnt = 0;
      foreach (sv_log[i]) if (sv_log[i][BX_W +: SEL_W] == 4'd11) cnt++;
      chk("s5_sel11", 32'(cnt), 64);
      chk("s5_trunc", tr_at(0), 0);

      // reset in the middle of a scan
      clear_logs(); pulse_start(3'd6, all_ent(64)); step(5);
      rst_n = 1'b0;
      #1;
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_bx_out", 32'(bx_out), 0);
      chk("rst_sel_valid", 32'(sel_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_truncated", 32'(truncated), 0);
      step(1);
      rst_n = 1'b1;
      clear_logs(); step(10);
      chk("rst_nreads", 32'(rd_log.size()), 0);
      chk("rst_nsv", 32'(sv_log.size()), 0);
      chk("rst_ndone", 32'(done_cyc.size()), 0);
      v = '0; v[0*NENT_W +: NENT_W] = 7'd2; v[3*NENT_W +: NENT_W] = 7'd1;
      clear_logs(); pulse_start(3'd7, v); step(12);
      chk("post_rst_nreads", 32'(rd_log.size()), 3);
      chk("post_rst_ndone", 32'(done_cyc.size()), 1);

      // random BX mix, the model checks every cycle
      repeat (60) begin
         v = '0;
         for (int m = 0; m < NMEM; m++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: val = 0;
               5, 6, 7:       val = int'($urandom_range(1, 5));
               8:             val = int'($urandom_range(1, 64));
               default:       val = int'($urandom_range(60, 127));
            endcase
            v[m*NENT_W +: NENT_W] = NENT_W'(val);
         end
         pulse_start(BX_W'($urandom), v);
         step(int'($urandom_range(1, 90)));
         if ($urandom_range(0, 14) == 0) begin
            rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
            step(1);
         end
      end
      step(120);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Per-BX read sequencer for the 12 input memories of the stream output path. On a BX start pulse it snapshots each memory's entry count, then issues one read per cycle, draining memories in fixed priority (lowest index first) and generating the memory read address. It emits the binary-encoded port select and BX, delayed to match the memory read latency, for the downstream select/concatenate stage that builds the 52-bit `{BX,sel,data}` word.

## Interface
- `NMEM`, 12, number of memories (index 0..11)
- `NENT_W`, 7, width of each entry count (0..64)
- `ADDR_W`, 6, memory read address width
- `BX_W`, 3, BX field width
- `RD_LAT`, 2, memory read latency in cycles (≥1)
- `MAX_READS`, 100, read budget per BX; reads stop after this many
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse marking a new BX
- `bx_in`  in  BX_W  BX number, sampled with `start`
- `nent`  in  NMEM*NENT_W  packed entry counts, memory i at `[i*NENT_W +: NENT_W]`, sampled with `start`
- `rd_en`  out  NMEM  one-hot read enable, registered
- `rd_addr`  out  ADDR_W  read address for the enabled memory, registered
- `sel`  out  4  binary index 0..11 of the memory whose data is valid this cycle
- `bx_out`  out  BX_W  BX tag aligned with `sel`
- `sel_valid`  out  1  `sel`/`bx_out` qualify memory data this cycle
- `busy`  out  1  high from the `start` sample through the last read issued
- `done`  out  1  one-cycle pulse at end of a BX's reads
- `truncated`  out  1  high with `done` if the budget or a new `start` cut the BX short

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: on `start`, latch `bx_in` and every `nent[i]` (values >64 clamp to 64), clear all read pointers and the read counter; go to SCAN.
- SCAN, each cycle: remaining[i] = snapshot[i] − ptr[i]; priority-encode lowest i with remaining > 0.
  - If found and counter < MAX_READS: register `rd_en`=1<<i, `rd_addr`=ptr[i][ADDR_W-1:0]; increment ptr[i] and the counter.
  - If none remain: go to DONE, `truncated`=0.
  - If counter == MAX_READS and reads remain: go to DONE, `truncated`=1.
- DONE: pulse `done` (with `truncated` as set); return to IDLE.
- `start` in SCAN or DONE: current BX ends immediately. `done` and `truncated`=1 pulse in that cycle when reads were still pending; otherwise `done` pulses normally. New snapshot taken the same edge; stay in or enter SCAN. `start` always wins.
- Delay line: `{valid, index, bx}` of each issued read passes through RD_LAT register stages to `sel_valid`/`sel`/`bx_out`. An in-flight entry from an aborted BX still emerges with its own BX tag.
- `sel` is plain binary 0..11. Codes 12..15 are never produced. `sel` holds its last value when `sel_valid`=0.

## Timing
- Reset: state IDLE; `rd_en`=0, `rd_addr`=0, `sel`=0, `bx_out`=0, `sel_valid`=0, `busy`=0, `done`=0, `truncated`=0. Pointers, counter, snapshot and delay line are cleared. Reset mid-BX discards all pending and in-flight reads.
- `start` sampled at edge k: first `rd_en` is valid after edge k+1. The matching `sel_valid` is valid after edge k+1+RD_LAT.
- Throughput: one read per cycle, no gaps. N total entries produce N consecutive `rd_en` cycles.
- `done` is valid after the edge following the last read. With all counts zero, `done` is valid after edge k+1 with no reads.
- `busy` is high from edge k until `done` is asserted.

## Structure
- Package `mem_read_pkg`: NMEM, NENT_W, ADDR_W, BX_W, SEL_W=4, state enum {IDLE, SCAN, DONE}.
- Sub-module `prio_enc12`: combinational lowest-index-nonzero encoder. Inputs are NMEM "remaining>0" bits; outputs are a 4-bit index and `any`.

## Test plan
- nent = {m0:2, m3:1, others 0}, bx_in=5 → rd_en sequence m0@addr0, m0@addr1, m3@addr0. sel_valid for 3 cycles with sel 0,0,3 and bx_out=5, starting RD_LAT after the first rd_en. done with truncated=0.
- All nent=0 → no rd_en. done one cycle after start, truncated=0.
- Every memory=64 (768 entries), MAX_READS=100 → exactly 100 reads, all 64 from m0 then 36 from m1 addr0..35. done with truncated=1.
- New start 3 cycles into a 10-entry BX (bx 1→2) → truncated=1 done pulse. The next read is addr0 of the new snapshot. The 3 in-flight sel_valid entries keep bx_out=1, followed by entries tagged 2.
- nent m11=70 → clamp to 64 reads, addr 0..63, sel=11 (4'b1011) for each.
- rst_n low for 1 cycle mid-SCAN → all outputs 0 at once, no further reads, IDLE. Next start behaves normally.
